// File: rtl/line_window_feeder.sv
// Raster pixel stream to 5-row window columns via four IMG_W-deep row buffers.
// Optional macro LINE_WINDOW_TOP_ZERO_EN zero-pads rows above the image top.
module line_window_feeder #(
   parameter int unsigned IMG_W    = 32,
   parameter int unsigned IMG_H    = 32,
   parameter int unsigned IN_WIDTH = 8,
   parameter int unsigned COL      = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pix_valid,
   input  logic [IN_WIDTH-1:0] pix_in,
   input  logic                frame_start,
   output logic [IN_WIDTH-1:0] out1,
   output logic [IN_WIDTH-1:0] out2,
   output logic [IN_WIDTH-1:0] out3,
   output logic [IN_WIDTH-1:0] out4,
   output logic [IN_WIDTH-1:0] out5,
   output logic                win_en,
   output logic                win_valid,
   output logic                frame_done
);

   localparam int unsigned NumBuf = COL - 1;
   localparam int unsigned CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
   localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);
   localparam logic [CW-1:0] ColFour = CW'(4);
   localparam logic [RW-1:0] RowFour = RW'(4);

   logic [IN_WIDTH-1:0] line_buf [NumBuf][IMG_W];
   logic [IN_WIDTH-1:0] rd       [NumBuf];

   logic [CW-1:0] col_q, col_d, col_eff;
   logic [RW-1:0] row_q, row_d, row_eff;
   logic [IN_WIDTH-1:0] out1_d, out2_d, out3_d, out4_d;
   logic win_valid_d, frame_done_d;

   always_comb begin
      // frame_start makes the current pixel (0,0) regardless of counter state
      col_eff = frame_start ? '0 : col_q;
      row_eff = frame_start ? '0 : row_q;
      col_d   = col_q;
      row_d   = row_q;
      if (pix_valid) begin
         if (col_eff == ColLast) begin
            col_d = '0;
            row_d = (row_eff == RowLast) ? '0 : row_eff + 1'b1;
         end else begin
            col_d = col_eff + 1'b1;
            row_d = row_eff;
         end
      end else if (frame_start) begin
         col_d = '0;
         row_d = '0;
      end

      for (int i = 0; i < NumBuf; i++) begin
         rd[i] = line_buf[i][col_eff];
      end

`ifdef LINE_WINDOW_TOP_ZERO_EN
      out4_d = (row_eff < RW'(1)) ? '0 : rd[0];
      out3_d = (row_eff < RW'(2)) ? '0 : rd[1];
      out2_d = (row_eff < RW'(3)) ? '0 : rd[2];
      out1_d = (row_eff < RW'(4)) ? '0 : rd[3];
`else
      out4_d = rd[0];
      out3_d = rd[1];
      out2_d = rd[2];
      out1_d = rd[3];
`endif

      win_valid_d  = pix_valid && (row_eff >= RowFour) && (col_eff >= ColFour);
      frame_done_d = pix_valid && (row_eff == RowLast) && (col_eff == ColLast);
   end

   // Buffer contents are intentionally unreset; win_valid hides stale rows.
   always_ff @(posedge clk) begin
      if (pix_valid) begin
         line_buf[0][col_eff] <= pix_in;
         for (int i = 1; i < NumBuf; i++) begin
            line_buf[i][col_eff] <= rd[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q      <= '0;
         row_q      <= '0;
         out1       <= '0;
         out2       <= '0;
         out3       <= '0;
         out4       <= '0;
         out5       <= '0;
         win_en     <= 1'b0;
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         win_en     <= pix_valid;
         win_valid  <= win_valid_d;
         frame_done <= frame_done_d;
         if (pix_valid) begin
            out5 <= pix_in;
            out4 <= out4_d;
            out3 <= out3_d;
            out2 <= out2_d;
            out1 <= out1_d;
         end
      end
   end

endmodule

// File: tb/tb_line_window_feeder.sv
// Directed bench for line_window_feeder on an 8x8 image, pixel = row*16+col.
// Expected columns follow LINE_WINDOW_TOP_ZERO_EN when the macro is defined.
module tb_line_window_feeder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pix_valid;
   logic [7:0] pix_in;
   logic       frame_start;
   logic [7:0] out1, out2, out3, out4, out5;
   logic       win_en, win_valid, frame_done;
   logic [39:0] outs;

   int n_cmp = 0;
   int n_err = 0;

   line_window_feeder #(
      .IMG_W    (8),
      .IMG_H    (8),
      .IN_WIDTH (8),
      .COL      (5)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pix_valid   (pix_valid),
      .pix_in      (pix_in),
      .frame_start (frame_start),
      .out1        (out1),
      .out2        (out2),
      .out3        (out3),
      .out4        (out4),
      .out5        (out5),
      .win_en      (win_en),
      .win_valid   (win_valid),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;
   assign outs = {out1, out2, out3, out4, out5};

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One accepted pixel at true position (r,c); flags checked against a position model.
   task automatic send_pix(input int r, input int c, input bit fs);
      @(negedge clk);
      pix_valid   = 1'b1;
      frame_start = fs;
      pix_in      = 8'(r * 16 + c);
      @(posedge clk);
      #1;
      pix_valid   = 1'b0;
      frame_start = 1'b0;
      check_val($sformatf("win_en(%0d,%0d)", r, c), 64'(win_en), 64'd1);
      check_val($sformatf("win_valid(%0d,%0d)", r, c), 64'(win_valid),
                64'((r >= 4) && (c >= 4)));
      check_val($sformatf("frame_done(%0d,%0d)", r, c), 64'(frame_done),
                64'((r == 7) && (c == 7)));
   endtask

   task automatic check_reset(input string tag);
      check_val({tag, "_outs"}, 64'(outs), 64'd0);
      check_val({tag, "_win_en"}, 64'(win_en), 64'd0);
      check_val({tag, "_win_valid"}, 64'(win_valid), 64'd0);
      check_val({tag, "_frame_done"}, 64'(frame_done), 64'd0);
   endtask

   initial begin
      rst_n       = 1'b0;
      pix_valid   = 1'b0;
      frame_start = 1'b0;
      pix_in      = 8'h00;
      #12;
      check_reset("por");
      @(negedge clk);
      rst_n = 1'b1;

      // Frame 0, with a three-cycle gap before (5,2)
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            if (r == 5 && c == 2) begin
               repeat (3) begin
                  @(posedge clk);
                  #1;
                  check_val("gap_win_en", 64'(win_en), 64'd0);
                  check_val("gap_hold", 64'(outs), 64'h11_21_31_41_51);
               end
            end
            send_pix(r, c, 1'b0);
            if (r == 4 && c == 4) check_val("col_4_4", 64'(outs), 64'h04_14_24_34_44);
            if (r == 5 && c == 2) check_val("col_5_2", 64'(outs), 64'h12_22_32_42_52);
            if (r == 7 && c == 7) check_val("col_7_7", 64'(outs), 64'h37_47_57_67_77);
         end
      end

      // Frame 1 starts by counter wrap, then reset arrives mid-row
      send_pix(0, 0, 1'b0);
`ifdef LINE_WINDOW_TOP_ZERO_EN
      check_val("f1_col_0_0", 64'(outs), 64'h00_00_00_00_00);
`else
      check_val("f1_col_0_0", 64'(outs), 64'h40_50_60_70_00);
`endif
      for (int c = 1; c < 4; c++) send_pix(0, c, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Frame 2 must restart at (0,0): window flags and frame_done track the model
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) send_pix(r, c, 1'b0);
      end

      // Frame 3 cut short at (2,5) by frame_start; frame 4 begins there
      for (int p = 0; p < 21; p++) send_pix(p / 8, p % 8, 1'b0);
      send_pix(0, 0, 1'b1);
`ifdef LINE_WINDOW_TOP_ZERO_EN
      check_val("fs_col_0_0", 64'(outs), 64'h00_00_00_00_00);
`else
      check_val("fs_col_0_0", 64'(outs), 64'h70_00_10_20_00);
`endif
      for (int p = 1; p < 11; p++) send_pix(p / 8, p % 8, 1'b0);
`ifdef LINE_WINDOW_TOP_ZERO_EN
      check_val("fs_col_1_2", 64'(outs), 64'h00_00_00_02_12);
`else
      check_val("fs_col_1_2", 64'(outs), 64'h02_12_22_02_12);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
